// File: rtl/event_ingress_fifo.sv
// rtl/event_ingress_fifo.sv - DVS event validation, downscaling, window tagging and FWFT buffering
// Optional timestamp order check enabled by defining EVT_TS_ORDER_CHECK_EN.
module event_ingress_fifo #(
  parameter int MAX_X_COORD    = 128,
  parameter int MAX_Y_COORD    = 128,
  parameter int INPUT_BIT_TIME = 32,
  parameter int INPUT_BIT_X    = 8,
  parameter int INPUT_BIT_Y    = 8,
  parameter int SCALE_SHIFT    = 0,
  parameter int WINDOW_LEN     = 100000,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_BITS       = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [INPUT_BIT_TIME-1:0]       timestamp,
  input  logic [INPUT_BIT_X-1:0]          x_coord,
  input  logic [INPUT_BIT_Y-1:0]          y_coord,
  input  logic                            polarity,
  input  logic                            is_valid,
  output logic [INPUT_BIT_TIME-1:0]       out_timestamp,
  output logic [INPUT_BIT_X-1:0]          out_x,
  output logic [INPUT_BIT_Y-1:0]          out_y,
  output logic                            out_polarity,
  output logic                            out_win_first,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_BITS-1:0]             drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int W     = INPUT_BIT_TIME;
  localparam int EW    = W + INPUT_BIT_X + INPUT_BIT_Y + 2;
  localparam logic [W-1:0] WIN_LEN = W'(WINDOW_LEN);

  logic                   s1_valid_q;
  logic [W-1:0]           s1_ts_q;
  logic [INPUT_BIT_X-1:0] s1_x_q;
  logic [INPUT_BIT_Y-1:0] s1_y_q;
  logic                   s1_pol_q;

  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]    drop_count_q;
  logic                   first_seen_q;
  logic [W-1:0]           win_start_q;
`ifdef EVT_TS_ORDER_CHECK_EN
  logic [W-1:0]           last_ts_q;
  logic [W-1:0]           order_delta;
`endif

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          entry_d, head;
  logic [W-1:0]           win_elapsed;
  logic                   win_first, range_bad, order_bad, full_bad;
  logic                   empty, full, push, pop, drop;

  always_comb begin
    win_elapsed = s1_ts_q - win_start_q;
    win_first   = !first_seen_q || (win_elapsed >= WIN_LEN);
    range_bad   = (32'(s1_x_q) >= MAX_X_COORD) || (32'(s1_y_q) >= MAX_Y_COORD);
`ifdef EVT_TS_ORDER_CHECK_EN
    // Modular difference: a set MSB means the event lies in the past.
    order_delta = s1_ts_q - last_ts_q;
    order_bad   = first_seen_q && order_delta[W-1];
`else
    order_bad   = 1'b0;
`endif
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = !empty && out_ready;
    full_bad = full && !pop;
    push     = s1_valid_q && !range_bad && !order_bad && !full_bad;
    drop     = s1_valid_q && (range_bad || order_bad || full_bad);
    entry_d  = {s1_ts_q, s1_x_q >> SCALE_SHIFT, s1_y_q >> SCALE_SHIFT, s1_pol_q, win_first};
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Head is masked while empty so the unreset storage never reaches the outputs.
  assign {out_timestamp, out_x, out_y, out_polarity, out_win_first} = empty ? '0 : head;
  assign out_valid  = !empty;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign drop_count = drop_count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_ts_q      <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_pol_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_count_q <= '0;
      first_seen_q <= 1'b0;
      win_start_q  <= '0;
`ifdef EVT_TS_ORDER_CHECK_EN
      last_ts_q    <= '0;
`endif
    end else begin
      s1_valid_q <= is_valid;
      if (is_valid) begin
        s1_ts_q  <= timestamp;
        s1_x_q   <= x_coord;
        s1_y_q   <= y_coord;
        s1_pol_q <= polarity;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
`ifdef EVT_TS_ORDER_CHECK_EN
        last_ts_q <= s1_ts_q;
`endif
        if (win_first) begin
          win_start_q  <= s1_ts_q;
          first_seen_q <= 1'b1;
        end
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_event_ingress_fifo.sv
// tb/tb_event_ingress_fifo.sv - scoreboard bench for event_ingress_fifo (SCALE_SHIFT = 1)
module tb_event_ingress_fifo;

  typedef struct packed {
    logic [31:0] ts;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        p;
    logic        wf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] timestamp;
  logic [7:0]  x_coord, y_coord;
  logic        polarity, is_valid;
  logic [31:0] out_timestamp;
  logic [7:0]  out_x, out_y;
  logic        out_polarity, out_win_first, out_valid, out_ready;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb[$];
  exp_t e;
  logic        m_first;
  logic [31:0] m_win, m_last;

  event_ingress_fifo #(.SCALE_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .timestamp(timestamp), .x_coord(x_coord),
    .y_coord(y_coord), .polarity(polarity), .is_valid(is_valid),
    .out_timestamp(out_timestamp), .out_x(out_x), .out_y(out_y),
    .out_polarity(out_polarity), .out_win_first(out_win_first),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_ts", out_timestamp, e.ts);
        check("out_x", 32'(out_x), 32'(e.x));
        check("out_y", 32'(out_y), 32'(e.y));
        check("out_pol", 32'(out_polarity), 32'(e.p));
        check("out_wf", 32'(out_win_first), 32'(e.wf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reference model decides accept/drop when the event is driven.
  task automatic send(input logic [31:0] ts, input logic [7:0] x, input logic [7:0] y, input logic p);
    logic rbad, obad, fbad, wf;
    logic [31:0] d;
    timestamp = ts; x_coord = x; y_coord = y; polarity = p; is_valid = 1'b1;
    rbad = (x >= 8'd128) || (y >= 8'd128);
    d    = ts - m_last;
`ifdef EVT_TS_ORDER_CHECK_EN
    obad = m_first && d[31];
`else
    obad = 1'b0;
`endif
    fbad = (!out_ready) && (sb.size() >= 16);
    if (!(rbad || obad || fbad)) begin
      wf = !m_first || ((ts - m_win) >= 32'd100000);
      if (wf) begin m_win = ts; m_first = 1'b1; end
      m_last = ts;
      sb.push_back('{ts: ts, x: x >> 1, y: y >> 1, p: p, wf: wf});
    end
    step();
    is_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    sb.delete();
    m_first = 1'b0; m_win = '0; m_last = '0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) step();
    check("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0; timestamp = '0; x_coord = '0; y_coord = '0;
    polarity = 1'b0; is_valid = 1'b0; out_ready = 1'b1;
    m_first = 1'b0; m_win = '0; m_last = '0;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ts", out_timestamp, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Range check and latency
    send(32'd10, 8'd127, 8'd5, 1'b1);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("range_x", 32'(out_x), 32'd63);
    check("range_y", 32'(out_y), 32'd2);
    check("range_wf", 32'(out_win_first), 32'd1);
    send(32'd20, 8'd128, 8'd5, 1'b0);
    idle(2);
    check("range_drop", 32'(drop_count), 32'd1);
    wait_drain(10);

    // Window boundary
    do_reset();
    send(32'd0, 8'd2, 8'd2, 1'b0);
    send(32'd99999, 8'd4, 8'd4, 1'b1);
    send(32'd100000, 8'd6, 8'd6, 1'b0);
    wait_drain(10);
    check("win_drop", 32'(drop_count), 32'd0);

    // Timestamp order
    do_reset();
    send(32'd500, 8'd10, 8'd10, 1'b1);
    send(32'd400, 8'd12, 8'd12, 1'b1);
    idle(3);
`ifdef EVT_TS_ORDER_CHECK_EN
    check("order_drop", 32'(drop_count), 32'd1);
`else
    check("order_drop", 32'(drop_count), 32'd0);
`endif
    wait_drain(10);

    // Timestamp wrap
    do_reset();
    send(32'hFFFF_FFF0, 8'd1, 8'd1, 1'b0);
    send(32'h0000_0010, 8'd3, 8'd3, 1'b1);
    wait_drain(10);
    check("wrap_drop", 32'(drop_count), 32'd0);

    // Overflow and in-order drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(32'd1000 + i, 8'(i), 8'(2 * i), i[0]);
    idle(2);
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_drop", 32'(drop_count), 32'd4);
    check("hold_ts_a", out_timestamp, sb[0].ts);
    idle(3);
    check("hold_ts_b", out_timestamp, sb[0].ts);
    check("hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle(8);
    check("drain_half_level", 32'(fifo_level), 32'd8);
    idle(8);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    wait_drain(4);

    // Asynchronous reset mid-operation
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'd50 + i, 8'd7, 8'd7, 1'b1);
    send(32'd60, 8'd200, 8'd7, 1'b0);
    idle(2);
    check("mid_level", 32'(fifo_level), 32'd5);
    check("mid_drop", 32'(drop_count), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_level", 32'(fifo_level), 32'd0);
    check("async_drop", 32'(drop_count), 32'd0);
    step();
    reset = 1'b1;
    sb.delete();
    m_first = 1'b0; m_win = '0; m_last = '0;
    out_ready = 1'b1;
    idle(2);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
